// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and a parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Word is zero-extended to 9 bits; the extra zeros do not change the XOR.
  function automatic logic parity_of(input logic [8:0] word, input int parity);
    return (^word) ^ (parity == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake and serial-line signals of the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud down-counter: bit_tick marks the last clock of each CLK_DIV-clock bit.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int             CW  = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrapping from 0 back to TOP starts the next bit with no extra clock.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || cnt_q == '0) cnt_d = TOP;
    else                        cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// with back-to-back frames accepted in the last clock of the final stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_frame_if.slave bus
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int            BW       = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 bit_tick;
  logic                 last_stop;
  logic                 ready;
  logic                 hs;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  assign last_stop = (stop_q == 1'(STOP_BITS - 1));
  assign ready     = (state_q == IDLE) || (state_q == STOP && last_stop && bit_tick);
  assign hs        = bus.tx_valid && ready;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    stop_d   = stop_q;
    par_d    = par_q;
    tx_d     = tx_q;
    unique case (state_q)
      IDLE: ;
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      PAR: begin
        if (bit_tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (last_stop) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // A handshake only happens in IDLE or the final stop clock; either way a new frame starts.
    if (hs) begin
      state_d  = START;
      tx_d     = 1'b0;
      shift_d  = bus.tx_data;
      par_d    = parity_of(9'(bus.tx_data), PARITY);
      bitcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_ready = ready;
  assign bus.tx_done  = (state_q == STOP) && last_stop && bit_tick;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Four transmitter configurations (8N1, 8E1, 8O1, 7N2, all CLK_DIV=4) checked clock by clock
// against per-frame expected line/flag sequences queued at each modelled handshake.
module tb_uart_tx_frame;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rstn [4];
  logic       vld  [4];
  logic [7:0] dat  [4];
  logic       rdy  [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DB = (g == 3) ? 7 : 8;
    localparam int PB = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 2 : 1;

    uart_tx_frame_if #(.DATA_BITS(DB)) bus ();

    uart_tx_frame #(
      .CLK_DIV   (DIV),
      .DATA_BITS (DB),
      .PARITY    (PB),
      .STOP_BITS (SB)
    ) dut (
      .clk   (clk),
      .rst_n (rstn[g]),
      .bus   (bus)
    );

    assign bus.tx_valid = vld[g];
    assign bus.tx_data  = dat[g][DB-1:0];
    assign rdy[g]       = bus.tx_ready;

    // Each entry is {tx, tx_done, tx_busy, tx_ready} for one clock of the frame.
    logic [3:0] exp_q[$];

    task automatic push_frame(input logic [7:0] d);
      logic [15:0] bits;
      int n;
      int len;
      bits = '1;
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < DB; i++) begin
        bits[n] = d[i]; n++;
      end
      if (PB != 0) begin
        bits[n] = (^d[DB-1:0]) ^ (PB == 1); n++;
      end
      for (int i = 0; i < SB; i++) begin
        bits[n] = 1'b1; n++;
      end
      len = n * DIV;
      for (int k = 0; k < len; k++)
        exp_q.push_back({bits[k / DIV], k == len - 1, 1'b1, k == len - 1});
    endtask

    always @(negedge rstn[g]) exp_q.delete();

    always @(negedge clk) begin : mon
      logic [3:0] e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 4'b1001;
      chk($sformatf("line%0d", g), {bus.tx, bus.tx_done, bus.tx_busy, bus.tx_ready}, e);
      if (rstn[g] && vld[g] && e[0]) push_frame(dat[g]);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until the next edge that accepts it.
  task automatic send(input int g, input logic [7:0] d, input bit hold);
    int t;
    vld[g] = 1'b1;
    dat[g] = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy[g] && t < 200);
    chk($sformatf("accept%0d", g), rdy[g], 1);
    @(posedge clk);
    #1;
    if (!hold) vld[g] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rstn[i] = 1'b0;
      vld[i]  = 1'b0;
      dat[i]  = '0;
    end
    idle(3);
    for (int i = 0; i < 4; i++) rstn[i] = 1'b1;
    idle(2);

    send(0, 8'hA5, 1'b0);
    idle(45);
    send(1, 8'h07, 1'b0);
    send(2, 8'h07, 1'b0);
    idle(50);
    send(3, 8'h41, 1'b0);
    idle(45);

    send(0, 8'h55, 1'b1);
    send(0, 8'h0F, 1'b0);
    idle(45);

    send(0, 8'h3C, 1'b0);
    dat[0] = 8'h00;
    idle(10);
    vld[0] = 1'b1;
    dat[0] = 8'hFF;
    idle(1);
    vld[0] = 1'b0;
    idle(40);

    send(0, 8'h96, 1'b0);
    idle(17);
    #1;
    rstn[0] = 1'b0;
    #1;
    chk("rst_tx",    g_dut[0].bus.tx,       1);
    chk("rst_busy",  g_dut[0].bus.tx_busy,  0);
    chk("rst_ready", g_dut[0].bus.tx_ready, 1);
    chk("rst_done",  g_dut[0].bus.tx_done,  0);
    idle(2);
    rstn[0] = 1'b1;
    idle(2);
    send(0, 8'h3C, 1'b0);
    idle(45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter and the successor to the fixed 8N1 transmitter. It accepts one data word per valid/ready handshake and serialises it LSB-first with a start bit, optional parity and 1 or 2 stop bits. Bit timing comes from an internal baud divider, so one frame bit lasts `CLK_DIV` clocks. It sits between the byte-producing logic (FIFO or register file) and the `tx` pad.

## Interface

Parameters:

- `CLK_DIV`, default 16: clocks per UART bit. Legal values ≥2.
- `DATA_BITS`, default 8: data bits per frame. Legal values 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- Illegal parameter values are an elaboration error.

Ports:

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  the block accepts a word this cycle.
- `tx_data`  in  `DATA_BITS`  word to send; sampled only on handshake.
- `tx`  out  1  serial line, idle high, registered.
- `tx_busy`  out  1  a frame is in progress (state ≠ IDLE).
- `tx_done`  out  1  one-cycle pulse marking the last clock of the last stop bit.

## Operation

- **State machine:** states are IDLE, START, DATA, PAR, STOP.
- **Handshake:** a transfer occurs when `tx_valid && tx_ready`. On transfer, `tx_data` is latched into a shift register and the parity bit is computed from the latched word.
- **IDLE:** `tx` is 1. A transfer moves the FSM to START.
- **START:** `tx` = 0 for `CLK_DIV` clocks, then go to DATA.
- **DATA:** `tx` = shift_reg[0]. On each bit tick, shift right and increment the bit counter. After `DATA_BITS` bits, go to PAR if `PARITY` ≠ 0, otherwise go to STOP.
- **Parity bit:** even = XOR of the data bits. Odd = inverted XOR.
- **STOP:** `tx` = 1 for `STOP_BITS`×`CLK_DIV` clocks.
  - In the final clock of the last stop bit, assert `tx_done` and drive `tx_ready` = 1.
  - A transfer in that cycle goes straight to START (back-to-back frames with no idle gap). Otherwise go to IDLE.
- **`tx_ready` definition:** (state == IDLE) OR (state == STOP && last stop bit && baud count == 0). It is combinational from registered state and never depends on `tx_valid`.
- **Offers while busy:** `tx_valid` while `tx_ready` = 0 is ignored, and the word is not captured. Changes on `tx_data` after a transfer have no effect on the frame in flight.
- **Baud counter:** width `$clog2(CLK_DIV)`. It loads `CLK_DIV-1` on entering any bit and counts down. A bit tick occurs when the count is 0.
- **Bit counter:** width `$clog2(DATA_BITS+1)`.
- **Reset:** `rst_n` low forces state = IDLE, `tx` = 1, `tx_busy` = 0, `tx_done` = 0, shift register and counters = 0. `tx_ready` = 1 while in reset.
- **Reset mid-frame:** the frame is abandoned and `tx` returns to 1 asynchronously. No `tx_done` is emitted.

## Timing

- **Latency:** handshake at edge N makes `tx` = 0 from edge N (registered) through edge N+`CLK_DIV`.
- **Bit boundaries:** every bit, including parity and each stop bit, is exactly `CLK_DIV` clocks.
- **Frame length:** `CLK_DIV`×(1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) clocks.
- **`tx_done`:** high for exactly the last clock of the frame.
- **`tx_busy`:** rises at the edge after the handshake that leaves IDLE. During back-to-back frames it stays high with no gap.

## Structure

- **Package `uart_pkg`:**
  - `uart_tx_state_t` enum {IDLE, START, DATA, PAR, STOP}.
  - `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN` localparams.
  - This package is shared with the receiver.
- **Sub-module `uart_baud_gen`:** the down-counter, with inputs `clk`, `rst_n`, `restart` and output `bit_tick`. The receiver reuses it.
- **FSM, shift register, parity and handshake** live in `uart_tx_frame`.

## Test plan

- `CLK_DIV`=4, 8N1, send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks. `tx_done` pulses in clock 40. `tx_ready` is low in clocks 1–39.
- `PARITY`=2 (even), send 0x07 → parity bit = 1. `PARITY`=1 (odd), send 0x07 → parity bit = 0. Frame is 44 clocks.
- `tx_valid` held high with 0x55 then 0x0F → second start bit begins the clock after the first frame's last stop clock. No idle-high gap, `tx_busy` continuously 1, 80 clocks total.
- `DATA_BITS`=7, `STOP_BITS`=2, send 0x41 → data bits 1,0,0,0,0,0,1, then 8 clocks of stop high. `tx_done` pulses at clock 40.
- Mid-frame, change `tx_data` and pulse `tx_valid` → no capture, frame bits unchanged.
- Deassert `rst_n` during data bit 3 → `tx` = 1, `tx_busy` = 0, `tx_ready` = 1 immediately, no `tx_done`. After release, a 0x3C frame is correct.
